// File: rtl/slave_arbiter_pkg.sv
// Shared types and defaults for the two-master burst-memory arbiter.
// Holds the grant state encoding, owner identifiers and default bus geometry.
package slave_arbiter_pkg;

  localparam int ADDR_W_DEF  = 3;
  localparam int DATA_W_DEF  = 4;
  localparam int BEATS_DEF   = 8;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_RD = 2'd1,
    GNT_WR = 2'd2
  } state_t;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

endpackage

// File: rtl/slave_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the master
// that did not own the previous grant. Purely combinational.
module rr_arbiter2
  import slave_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] winner
);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    winner = 2'b00;
    case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = (last_owner == OWNER_M1) ? 2'b01 : 2'b10;
      default: winner = 2'b00;
    endcase
  end

endmodule

// File: rtl/slave_arbiter.sv
// Shares one burst-memory slave between masters M0 and M1, one whole read
// burst or write-plus-response at a time, with round-robin and a stall timeout.
module slave_arbiter
  import slave_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int BEATS   = BEATS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_ar_valid,
  input  logic [ADDR_W-1:0] m0_ar_addr,
  output logic              m0_ar_ready,
  output logic              m0_r_valid,
  input  logic              m0_r_ready,
  output logic [DATA_W-1:0] m0_r_data,
  input  logic              m0_aw_valid,
  input  logic [ADDR_W-1:0] m0_aw_addr,
  output logic              m0_aw_ready,
  input  logic              m0_w_valid,
  input  logic [DATA_W-1:0] m0_w_data,
  output logic              m0_w_ready,
  output logic              m0_b_valid,
  input  logic              m0_b_ready,
  input  logic              m1_ar_valid,
  input  logic [ADDR_W-1:0] m1_ar_addr,
  output logic              m1_ar_ready,
  output logic              m1_r_valid,
  input  logic              m1_r_ready,
  output logic [DATA_W-1:0] m1_r_data,
  input  logic              m1_aw_valid,
  input  logic [ADDR_W-1:0] m1_aw_addr,
  output logic              m1_aw_ready,
  input  logic              m1_w_valid,
  input  logic [DATA_W-1:0] m1_w_data,
  output logic              m1_w_ready,
  output logic              m1_b_valid,
  input  logic              m1_b_ready,
  output logic              s_ar_valid,
  output logic [ADDR_W-1:0] s_ar_addr,
  input  logic              s_ar_ready,
  input  logic              s_r_valid,
  output logic              s_r_ready,
  input  logic [DATA_W-1:0] s_r_data,
  output logic              s_aw_valid,
  output logic [ADDR_W-1:0] s_aw_addr,
  input  logic              s_aw_ready,
  output logic              s_w_valid,
  output logic [DATA_W-1:0] s_w_data,
  input  logic              s_w_ready,
  input  logic              s_b_valid,
  output logic              s_b_ready,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              timeout_err
);

  localparam int BCNT_W = $clog2(BEATS + 1);
  localparam int TCNT_W = $clog2(TIMEOUT);

  state_t            state, state_nxt;
  logic [1:0]        grant_nxt, winner;
  logic              last_owner, last_owner_nxt;
  logic [BCNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic [TCNT_W-1:0] to_cnt, to_cnt_nxt;
  logic              timeout_nxt;
  logic              rd0, rd1, wr0, wr1;
  logic              any_hs, r_hs, b_hs, rd_done, wr_done, to_hit;

  rr_arbiter2 u_rr (
    .req        ({m1_ar_valid | m1_aw_valid, m0_ar_valid | m0_aw_valid}),
    .last_owner (last_owner),
    .winner     (winner)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= 2'b00;
      last_owner  <= OWNER_M1;
      beat_cnt    <= '0;
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      last_owner  <= last_owner_nxt;
      beat_cnt    <= beat_cnt_nxt;
      to_cnt      <= to_cnt_nxt;
      timeout_err <= timeout_nxt;
    end
  end

  assign r_hs    = s_r_valid & s_r_ready;
  assign b_hs    = s_b_valid & s_b_ready;
  assign any_hs  = (s_ar_valid & s_ar_ready) | (s_aw_valid & s_aw_ready)
                 | (s_w_valid & s_w_ready) | r_hs | b_hs;
  assign rd_done = (state == GNT_RD) && r_hs && (beat_cnt == BCNT_W'(BEATS - 1));
  assign wr_done = (state == GNT_WR) && b_hs;
  assign to_hit  = !any_hs && (to_cnt == TCNT_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_owner_nxt = last_owner;
    beat_cnt_nxt   = beat_cnt;
    to_cnt_nxt     = to_cnt;
    timeout_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (|winner) begin
          grant_nxt = winner;
          // Read wins over write within the same master.
          state_nxt = (winner[1] ? m1_ar_valid : m0_ar_valid) ? GNT_RD : GNT_WR;
        end
      end
      default: begin
        if (r_hs) beat_cnt_nxt = beat_cnt + 1'b1;
        to_cnt_nxt = any_hs ? '0 : to_cnt + 1'b1;
        if (rd_done || wr_done || to_hit) begin
          state_nxt      = IDLE;
          grant_nxt      = 2'b00;
          last_owner_nxt = grant[1] ? OWNER_M1 : OWNER_M0;
          beat_cnt_nxt   = '0;
          to_cnt_nxt     = '0;
          timeout_nxt    = to_hit;
        end
      end
    endcase
  end

  // Only the channels of the granted transaction kind are opened, so a
  // pending write cannot slip into the slave during its owner's read grant.
  assign rd0 = (state == GNT_RD) && grant[0];
  assign rd1 = (state == GNT_RD) && grant[1];
  assign wr0 = (state == GNT_WR) && grant[0];
  assign wr1 = (state == GNT_WR) && grant[1];

  always_comb begin
    s_ar_valid = 1'b0;
    s_ar_addr  = '0;
    s_r_ready  = 1'b0;
    s_aw_valid = 1'b0;
    s_aw_addr  = '0;
    s_w_valid  = 1'b0;
    s_w_data   = '0;
    s_b_ready  = 1'b0;
    if (rd0 || rd1) begin
      s_ar_valid = rd1 ? m1_ar_valid : m0_ar_valid;
      s_ar_addr  = rd1 ? m1_ar_addr  : m0_ar_addr;
      s_r_ready  = rd1 ? m1_r_ready  : m0_r_ready;
    end
    if (wr0 || wr1) begin
      s_aw_valid = wr1 ? m1_aw_valid : m0_aw_valid;
      s_aw_addr  = wr1 ? m1_aw_addr  : m0_aw_addr;
      s_w_valid  = wr1 ? m1_w_valid  : m0_w_valid;
      s_w_data   = wr1 ? m1_w_data   : m0_w_data;
      s_b_ready  = wr1 ? m1_b_ready  : m0_b_ready;
    end
  end

  assign m0_ar_ready = rd0 & s_ar_ready;
  assign m0_r_valid  = rd0 & s_r_valid;
  assign m0_r_data   = rd0 ? s_r_data : '0;
  assign m0_aw_ready = wr0 & s_aw_ready;
  assign m0_w_ready  = wr0 & s_w_ready;
  assign m0_b_valid  = wr0 & s_b_valid;

  assign m1_ar_ready = rd1 & s_ar_ready;
  assign m1_r_valid  = rd1 & s_r_valid;
  assign m1_r_data   = rd1 ? s_r_data : '0;
  assign m1_aw_ready = wr1 & s_aw_ready;
  assign m1_w_ready  = wr1 & s_w_ready;
  assign m1_b_valid  = wr1 & s_b_valid;

  assign busy = (state != IDLE);

endmodule

// File: doc/slave_arbiter.md
Name: slave_arbiter

Overview:
Two-master arbiter that shares the single 8-entry, 4-bit burst memory slave between master ports M0 and M1. It grants one whole transaction at a time: a read burst, or a write burst plus its response. Grants alternate round-robin between masters. It sits between the two masters and the slave, and muxes every AR/R/AW/W/B channel signal.

Parameters:
ADDR_W, 3, address width on all ports
DATA_W, 4, data width on all ports
BEATS, 8, data beats per burst (matches slave memory depth)
TIMEOUT, 64, idle cycles without any slave-side handshake before a grant is forcibly released

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous and active-high
mN_ar_valid  input  1  read address valid (N = 0,1)
mN_ar_addr  input  ADDR_W  read address
mN_ar_ready  output  1  read address ready
mN_r_valid  output  1  read data valid
mN_r_ready  input  1  read data ready
mN_r_data  output  DATA_W  read data
mN_aw_valid  input  1  write address valid
mN_aw_addr  input  ADDR_W  write address
mN_aw_ready  output  1  write address ready
mN_w_valid  input  1  write data valid
mN_w_data  input  DATA_W  write data
mN_w_ready  output  1  write data ready
mN_b_valid  output  1  write response valid
mN_b_ready  input  1  write response ready
s_ar_valid, s_ar_addr, s_r_ready, s_aw_valid, s_aw_addr, s_w_valid, s_w_data, s_b_ready  output  1/ADDR_W/DATA_W  slave-side drives
s_ar_ready, s_r_valid, s_r_data, s_aw_ready, s_w_ready, s_b_valid  input  1/DATA_W  slave-side returns
grant  output  2  one-hot current owner (bit0 = M0, bit1 = M1); 00 when idle
busy  output  1  high while any grant is held
timeout_err  output  1  one-cycle pulse when a grant is released by timeout

Behaviour:
- Reset (async, rst = 1):
  - state = IDLE, grant = 00, last_owner = M1 (so M0 wins the first tie), beat counter = 0, timeout counter = 0.
  - All s_* outputs, all mN_* outputs, busy and timeout_err are 0.
- States: IDLE, GNT_RD, GNT_WR.
- Request per master: reqN = mN_ar_valid | mN_aw_valid.
- IDLE arbitration:
  - If only one reqN is high, that master wins.
  - If both are high, the master other than last_owner wins.
  - The winner's kind is chosen by the winner's own ar_valid: read if set, otherwise write (read has priority within a master).
  - Registered decision: grant and state update on the clock edge after the request is sampled. Routing starts in that granted cycle.
- Routing while granted:
  - The owner's ar/aw/w/r_ready/b_ready signals pass combinationally to s_*.
  - The slave's ready/valid/data signals pass combinationally to the owner.
  - The non-owner sees all outputs 0, including r_data = 0.
  - In IDLE, all s_* outputs are 0.
- GNT_RD:
  - Count beats on s_r_valid & s_r_ready.
  - When the count reaches BEATS, return to IDLE on the next edge, set last_owner = owner, clear the counter.
- GNT_WR:
  - Complete on s_b_valid & s_b_ready. Return to IDLE on the next edge and set last_owner.
  - W beats are not counted.
- Timeout:
  - The timeout counter increments each granted cycle with no ar/aw/w/r/b handshake, and clears on any handshake.
  - At TIMEOUT - 1, release to IDLE, pulse timeout_err for 1 cycle, and update last_owner.
- A new request arriving mid-grant waits; it is never pre-empted.
- A master dropping valid mid-burst does not end the grant; only completion or timeout does.
- Back-to-back: there is always at least 1 IDLE cycle between grants.
- busy = (state != IDLE). grant is registered.
- rst asserted mid-burst aborts immediately to reset values. Slave-side recovery is the slave's own reset's responsibility.
- Counter widths: $clog2(BEATS + 1) for beats and $clog2(TIMEOUT) for timeout. No wrap-around is reachable because both counters clear on release.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/GNT_RD/GNT_WR)
  - ADDR_W, DATA_W, BEATS defaults
  - owner encoding constants
- One natural sub-module, rr_arbiter2: two requests in, last_owner in, one-hot winner out, purely combinational.
- The top level holds the FSM, counters and channel muxes.

Test Plan:
- M0 ar_valid alone, addr 0, r_ready held 1 -> grant = 01 one cycle later; M0 receives 8 beats of s_r_data; grant returns to 00; M1 outputs stay 0 throughout.
- M0 and M1 both ar_valid in the same cycle after reset -> M0 granted first, M1 granted after M0's 8th beat plus one IDLE cycle; then repeat with both requesting -> M0 again (alternation follows last_owner = M1).
- M1 write: aw_valid, 8 w beats of data 4'h1..4'h8, b_ready = 1 -> grant = 10 until s_b handshake; a subsequent M0 read returns 1..8 in order.
- M0 asserts both ar_valid and aw_valid -> read granted first (state GNT_RD); write granted on the following arbitration.
- Granted M0 read with r_ready held 0 for 64 cycles -> timeout_err pulses once, grant = 00, M1's pending request granted next.
- rst pulsed mid-read at beat 3 -> all outputs 0 asynchronously; after release, a fresh M1 request is granted normally.
